excp_mtimer: RTL and testbench

Parametrised machine-timer and interrupt generator for the exception unit. It holds one 2*XLEN-bit `mtime` counter, advanced by a prescaled tick, and NUM_CH independent `mtimecmp` comparators. Each comparator drives its own level-sensitive timer interrupt toward the exception/CSR logic. All registers are memory-mapped through a single-beat request/response port, because `mtime` and `mtimecmp` are not CSRs.

---
 rtl/excp_mtimer_pkg.sv | 30 +++
 rtl/excp_mtimer_cmp.sv | 46 ++++
 rtl/excp_mtimer.sv | 167 ++++++++++++++++
 tb/tb_excp_mtimer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/excp_mtimer_pkg.sv
// Shared constants for the machine timer: register byte offsets, CTRL field
// positions, the MTIMECMP reset value and small address-decode helpers.
package excp_mtimer_pkg;

  localparam logic [7:0] OFF_MTIME_LO = 8'h00;
  localparam logic [7:0] OFF_MTIME_HI = 8'h04;
  localparam logic [7:0] OFF_CTRL     = 8'h08;
  localparam logic [7:0] OFF_MASK     = 8'h0C;
  localparam logic [7:0] OFF_CMP_BASE = 8'h10;
  localparam logic [7:0] CMP_STRIDE   = 8'h08;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_DIV_LSB = 8;

  // Wide enough for any supported XLEN; callers slice the low 2*XLEN bits.
  localparam logic [127:0] MTIMECMP_RST = '1;

  // Word index (byte offset >> 2) of a register.
  function automatic logic [5:0] word_of(input logic [7:0] off);
    return off[7:2];
  endfunction

  // Word index of MTIMECMP_LO/HI for one channel.
  function automatic logic [5:0] cmp_word(input int ch, input logic hi);
    logic [7:0] off;
    off = OFF_CMP_BASE + 8'(ch) * CMP_STRIDE + (hi ? 8'h04 : 8'h00);
    return off[7:2];
  endfunction

endpackage

// File: rtl/excp_mtimer_cmp.sv
// One timer channel: its mtimecmp register, half-word write handling,
// the unsigned mtime >= mtimecmp comparator and the registered interrupt.
module excp_mtimer_cmp
  import excp_mtimer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_lo_i,
  input  logic              wr_hi_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [2*XLEN-1:0] mtime_i,
  input  logic              mask_i,
  output logic [2*XLEN-1:0] cmp_o,
  output logic              irq_o
);

  logic [2*XLEN-1:0] cmp_d, cmp_q;
  logic              irq_d, irq_q;

  // Next compare value and next interrupt level from the current register state.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    cmp_d = cmp_q;
    if (wr_lo_i) cmp_d[XLEN-1:0]      = wdata_i;
    if (wr_hi_i) cmp_d[2*XLEN-1:XLEN] = wdata_i;
    irq_d = (mtime_i >= cmp_q) && mask_i;
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_q <= MTIMECMP_RST[2*XLEN-1:0];
      irq_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      cmp_q <= cmp_d;
      irq_q <= irq_d;
    end
  end

  assign cmp_o = cmp_q;
  assign irq_o = irq_q;

endmodule

// File: rtl/excp_mtimer.sv
// Machine timer: 2*XLEN-bit mtime advanced by a prescaled tick, NUM_CH
// compare channels with level interrupts, and a single-beat register port.
// Optional build macro EXCP_TMR_IRQ_MASK_EN adds the MASK register at 0x0C.
module excp_mtimer
  import excp_mtimer_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NUM_CH = 4,
  parameter int PSC_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_i,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [7:0]        req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic [NUM_CH-1:0] irq_o
);

  localparam int TW = 2 * XLEN;

  logic [5:0]        word;
  logic              wr_en, mapped;
  logic              hit_lo, hit_hi, hit_ctrl, hit_mask;
  logic [NUM_CH-1:0] hit_cmp_lo, hit_cmp_hi, mask, irq;
  logic [TW-1:0]     cmp_val [NUM_CH];
  logic              unused_addr_lsb;

  logic              en_d, en_q;
  logic [PSC_W-1:0]  div_d, div_q;
  logic [PSC_W-1:0]  psc_d, psc_q;
  logic [TW-1:0]     mtime_d, mtime_q;
  logic              inc;
  logic [XLEN-1:0]   rdata_sel;
  logic              rsp_valid_d, rsp_valid_q;
  logic [XLEN-1:0]   rsp_rdata_d, rsp_rdata_q;
  logic              rsp_err_d, rsp_err_q;

  assign req_ready       = 1'b1;
  assign word            = req_addr[7:2];
  assign unused_addr_lsb = ^req_addr[1:0];
  assign wr_en           = req_valid && req_write;

  assign hit_lo   = (word == word_of(OFF_MTIME_LO));
  assign hit_hi   = (word == word_of(OFF_MTIME_HI));
  assign hit_ctrl = (word == word_of(OFF_CTRL));

`ifdef EXCP_TMR_IRQ_MASK_EN
  logic [NUM_CH-1:0] mask_d, mask_q;

  assign hit_mask = (word == word_of(OFF_MASK));

  // Per-channel interrupt enable, written as a whole word.
  always_comb begin
    mask_d = mask_q;
    if (wr_en && hit_mask) mask_d = req_wdata[NUM_CH-1:0];
  end

  // Mask register, all channels enabled out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mask_q <= '1;
    else        mask_q <= mask_d;
  end

  assign mask = mask_q;
`else
  assign hit_mask = 1'b0;
  assign mask     = '1;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign hit_cmp_lo[g] = (word == cmp_word(g, 1'b0));
    assign hit_cmp_hi[g] = (word == cmp_word(g, 1'b1));

    excp_mtimer_cmp #(.XLEN(XLEN)) u_cmp (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_lo_i (wr_en && hit_cmp_lo[g]),
      .wr_hi_i (wr_en && hit_cmp_hi[g]),
      .wdata_i (req_wdata),
      .mtime_i (mtime_q),
      .mask_i  (mask[g]),
      .cmp_o   (cmp_val[g]),
      .irq_o   (irq[g])
    );
  end

  assign irq_o  = irq;
  assign mapped = hit_lo || hit_hi || hit_ctrl || hit_mask || (|hit_cmp_lo) || (|hit_cmp_hi);

  // Prescaler, mtime advance and CTRL; software writes override the tick path.
  always_comb begin
    en_d    = en_q;
    div_d   = div_q;
    psc_d   = psc_q;
    mtime_d = mtime_q;
    inc     = 1'b0;
    if (en_q && tick_i) begin
      if (psc_q == div_q) begin
        psc_d = '0;
        inc   = 1'b1;
      end else begin
        psc_d = psc_q + PSC_W'(1);
      end
    end
    if (inc) mtime_d = mtime_q + TW'(1);
    // A CTRL write restarts the prescale period with the new divisor.
    if (wr_en && hit_ctrl) begin
      en_d  = req_wdata[CTRL_EN_BIT];
      div_d = req_wdata[CTRL_DIV_LSB +: PSC_W];
      psc_d = '0;
    end
    // Writing either mtime half discards any increment from this cycle.
    if (wr_en && hit_lo) mtime_d = {mtime_q[TW-1:XLEN], req_wdata};
    if (wr_en && hit_hi) mtime_d = {req_wdata, mtime_q[XLEN-1:0]};
  end

  // Read data mux over the pre-edge register values; unmapped reads return 0.
  always_comb begin
    rdata_sel = '0;
    if (hit_lo) rdata_sel = mtime_q[XLEN-1:0];
    if (hit_hi) rdata_sel = mtime_q[TW-1:XLEN];
    if (hit_ctrl) begin
      rdata_sel[CTRL_EN_BIT]             = en_q;
      rdata_sel[CTRL_DIV_LSB +: PSC_W]   = div_q;
    end
    if (hit_mask) rdata_sel[NUM_CH-1:0] = mask;
    for (int i = 0; i < NUM_CH; i++) begin
      if (hit_cmp_lo[i]) rdata_sel = cmp_val[i][XLEN-1:0];
      if (hit_cmp_hi[i]) rdata_sel = cmp_val[i][TW-1:XLEN];
    end
    rsp_valid_d = req_valid;
    rsp_rdata_d = (req_valid && !req_write && mapped) ? rdata_sel : '0;
    rsp_err_d   = req_valid && !mapped;
  end

  // Timer state and one-cycle-late response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q        <= 1'b0;
      div_q       <= '0;
      psc_q       <= '0;
      mtime_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      en_q        <= en_d;
      div_q       <= div_d;
      psc_q       <= psc_d;
      mtime_q     <= mtime_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_excp_mtimer.sv
// Directed self-checking bench for excp_mtimer (XLEN=32, NUM_CH=4, PSC_W=8).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_excp_mtimer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_i = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [3:0]  irq_o;

  int n_checks = 0;
  int n_fail   = 0;

  excp_mtimer #(.XLEN(32), .NUM_CH(4), .PSC_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_i    (tick_i),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .irq_o     (irq_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "time limit");
  end

  // One request issued at a falling edge; its response is captured one cycle later.
  task automatic bus(input logic w, input logic [7:0] a, input logic [31:0] d,
                     output logic v, output logic [31:0] rd, output logic e);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(negedge clk);
    v = rsp_valid; rd = rsp_rdata; e = rsp_err;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic v, e;
    logic [31:0] rd;
    bus(1'b1, a, d, v, rd, e);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
    logic v, e;
    logic [31:0] rd;
    bus(1'b0, a, 32'h0, v, rd, e);
    n_checks++;
    if ({v, e, rd} !== {1'b1, 1'b0, exp}) begin
      n_fail++;
      $display("FAIL %s: valid=%b err=%b data=%h, want valid=1 err=0 data=%h", name, v, e, rd, exp);
    end
  endtask

  task automatic test_reset();
    logic [7:0]  addrs [7] = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h28, 8'h2C};
    logic [31:0] exps  [7] = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF};
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_rdata, irq_o} !== '0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b err=%b data=%h irq=%b ready=%b, want 0/0/0/0 ready=1",
               rsp_valid, rsp_err, rsp_rdata, irq_o, req_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 7; i++) rd_chk($sformatf("reset_read_%h", addrs[i]), addrs[i], exps[i]);
  endtask

  task automatic test_prescaler();
    logic v, e;
    logic [31:0] rd;
    bus(1'b1, 8'h08, 32'h0000_0301, v, rd, e);
    n_checks++;
    if ({v, e, rd} !== {1'b1, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL write_response: valid=%b err=%b data=%h, want 1/0/0", v, e, rd);
    end
    tick_i = 1'b1; repeat (16) @(negedge clk); tick_i = 1'b0;
    rd_chk("div3_16ticks_lo", 8'h00, 32'd4);
    rd_chk("div3_16ticks_hi", 8'h04, 32'd0);
    // Count must be back at 0: three more ticks do not advance, the fourth does.
    tick_i = 1'b1; repeat (3) @(negedge clk); tick_i = 1'b0;
    rd_chk("div3_plus3", 8'h00, 32'd4);
    tick_i = 1'b1; @(negedge clk); tick_i = 1'b0;
    rd_chk("div3_plus4", 8'h00, 32'd5);
    wr(8'h08, 32'h0);
    tick_i = 1'b1; repeat (5) @(negedge clk); tick_i = 1'b0;
    rd_chk("en0_holds", 8'h00, 32'd5);
    wr(8'h08, 32'hFFFF_FFFF);
    rd_chk("ctrl_unimpl_bits", 8'h08, 32'h0000_FF01);
    wr(8'h08, 32'h0);
  endtask

  task automatic test_irq_compare();
    logic [3:0] exp;
    wr(8'h00, 32'h0);
    wr(8'h20, 32'd5);
    wr(8'h24, 32'd0);
    wr(8'h08, 32'h1);
    tick_i = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      exp = (k >= 6) ? 4'b0100 : 4'b0000;
      n_checks++;
      if (irq_o !== exp) begin
        n_fail++;
        $display("FAIL irq_rise_cycle%0d: irq=%b, want %b", k, irq_o, exp);
      end
    end
    tick_i = 1'b0;
    wr(8'h20, 32'd100);
    n_checks++;
    if (irq_o !== 4'b0100) begin
      n_fail++;
      $display("FAIL irq_hold_at_write_edge: irq=%b, want 0100", irq_o);
    end
    @(negedge clk);
    n_checks++;
    if (irq_o !== 4'b0000) begin
      n_fail++;
      $display("FAIL irq_fall_after_cmp_raise: irq=%b, want 0000", irq_o);
    end
    wr(8'h08, 32'h0);
  endtask

  task automatic test_wrap();
    wr(8'h04, 32'hFFFF_FFFF);
    wr(8'h00, 32'hFFFF_FFFE);
    @(negedge clk);
    n_checks++;
    if (irq_o !== 4'b0100) begin
      n_fail++;
      $display("FAIL wrap_minus2: irq=%b, want 0100", irq_o);
    end
    wr(8'h08, 32'h1);
    tick_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (irq_o !== 4'b0100) begin
      n_fail++;
      $display("FAIL wrap_at_allones: irq=%b, want 0100", irq_o);
    end
    @(negedge clk);
    tick_i = 1'b0;
    n_checks++;
    if (irq_o !== 4'b1111) begin
      n_fail++;
      $display("FAIL wrap_allones_compare: irq=%b, want 1111", irq_o);
    end
    @(negedge clk);
    n_checks++;
    if (irq_o !== 4'b0000) begin
      n_fail++;
      $display("FAIL wrap_cleared: irq=%b, want 0000", irq_o);
    end
    rd_chk("wrap_lo", 8'h00, 32'h0);
    rd_chk("wrap_hi", 8'h04, 32'h0);
    wr(8'h08, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic v, e;
    logic [31:0] rd;
    wr(8'h08, 32'h1);
    tick_i = 1'b1;
    wr(8'h00, 32'h10);
    tick_i = 1'b0;
    rd_chk("write_beats_increment", 8'h00, 32'h10);
    // A read in a ticking cycle returns the value before that cycle's increment.
    tick_i = 1'b1;
    bus(1'b0, 8'h00, 32'h0, v, rd, e);
    tick_i = 1'b0;
    n_checks++;
    if ({v, e, rd} !== {1'b1, 1'b0, 32'h10}) begin
      n_fail++;
      $display("FAIL read_pre_edge: valid=%b err=%b data=%h, want 1/0/00000010", v, e, rd);
    end
    rd_chk("read_after_inc", 8'h00, 32'h11);
    wr(8'h08, 32'h0);
  endtask

  task automatic test_unmapped();
    logic v, e;
    logic [31:0] rd;
    bus(1'b0, 8'h80, 32'h0, v, rd, e);
    n_checks++;
    if ({v, e, rd} !== {1'b1, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL unmapped_read_80: valid=%b err=%b data=%h, want 1/1/0", v, e, rd);
    end
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rsp_single_cycle: valid=%b, want 0", rsp_valid);
    end
    bus(1'b1, 8'h30, 32'h0, v, rd, e);
    n_checks++;
    if ({v, e, rd} !== {1'b1, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL unmapped_write_ch4: valid=%b err=%b data=%h, want 1/1/0", v, e, rd);
    end
    rd_chk("ch1_after_ch4_write", 8'h18, 32'hFFFF_FFFF);
    bus(1'b0, 8'h0C, 32'h0, v, rd, e);
    n_checks++;
`ifdef EXCP_TMR_IRQ_MASK_EN
    if ({v, e, rd} !== {1'b1, 1'b0, 32'h0000_000F}) begin
      n_fail++;
      $display("FAIL mask_reset_read: valid=%b err=%b data=%h, want 1/0/0000000f", v, e, rd);
    end
`else
    if ({v, e, rd} !== {1'b1, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL mask_addr_unmapped: valid=%b err=%b data=%h, want 1/1/0", v, e, rd);
    end
`endif
  endtask

`ifdef EXCP_TMR_IRQ_MASK_EN
  task automatic test_mask();
    wr(8'h0C, 32'h0);
    wr(8'h10, 32'h0);
    wr(8'h14, 32'h0);
    @(negedge clk);
    n_checks++;
    if (irq_o !== 4'b0000) begin
      n_fail++;
      $display("FAIL mask_blocks: irq=%b, want 0000", irq_o);
    end
    wr(8'h0C, 32'h1);
    @(negedge clk);
    n_checks++;
    if (irq_o !== 4'b0001) begin
      n_fail++;
      $display("FAIL mask_enable_ch0: irq=%b, want 0001", irq_o);
    end
  endtask
`endif

  task automatic test_async_reset();
    wr(8'h10, 32'h0);
    wr(8'h14, 32'h0);
    @(negedge clk);
    n_checks++;
    if (irq_o[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL ch0_cmp0_irq: irq=%b, want bit0=1", irq_o);
    end
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h18;
    @(posedge clk);
    #2;
    n_checks++;
    if ({rsp_valid, rsp_rdata} !== {1'b1, 32'hFFFF_FFFF}) begin
      n_fail++;
      $display("FAIL pre_reset_rsp: valid=%b data=%h, want 1/ffffffff", rsp_valid, rsp_rdata);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_rdata, irq_o} !== '0) begin
      n_fail++;
      $display("FAIL async_reset_clear: valid=%b err=%b data=%h irq=%b, want all 0",
               rsp_valid, rsp_err, rsp_rdata, irq_o);
    end
    req_valid = 1'b0; req_addr = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd_chk("post_reset_mtime", 8'h00, 32'h0);
    rd_chk("post_reset_cmp0", 8'h10, 32'hFFFF_FFFF);
  endtask

  initial begin
    test_reset();
    test_prescaler();
    test_irq_compare();
    test_wrap();
    test_back_to_back();
    test_unmapped();
`ifdef EXCP_TMR_IRQ_MASK_EN
    test_mask();
`endif
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
